// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, key roles
// and a width helper used to size counters.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;
  localparam int KEY_LAP   = 2;
  localparam int NUM_KEYS  = 4;

  // $clog2 clamped to one bit so degenerate parameters still give a legal vector
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and counter-control outputs of the stopwatch controller.
// master = controller side, slave = board/counter side.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic [NUM_KEYS-1:0] KEY;
  logic                count_en;
  logic                count_clr;
  logic                running;
  logic                hold;
  logic [1:0]          state;

  modport master (
    input  KEY,
    output count_en, count_clr, running, hold, state
  );

  modport slave (
    output KEY,
    input  count_en, count_clr, running, hold, state
  );

endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push-button: 2-flop synchroniser, consecutive-cycle debounce and a
// one-cycle press pulse on the debounced 1->0 edge.
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_raw,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // any cycle matching the accepted level restarts the stability run
      if (sync_2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_2;
          cnt   <= '0;
          press <= ~sync_2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced keys drive start/stop, clear and lap hold,
// and a prescaler generates the one-per-second count_en pulse.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | stopped, prescaler at 0, counter expected at 000
//   ST_RUN   | prescaler advancing, count_en on every wrap
//   ST_PAUSE | stopped, prescaler holds the partial second
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clock,
  input  logic Reset,
  stopwatch_ctrl_if.master bus
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic ev_start;
  logic ev_clear;
  logic ev_lap;
  logic unused_key;

  assign unused_key = bus.KEY[NUM_KEYS-1];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .Clock   (Clock),
    .Reset   (Reset),
    .key_raw (bus.KEY[KEY_START]),
    .press   (ev_start)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .Clock   (Clock),
    .Reset   (Reset),
    .key_raw (bus.KEY[KEY_CLEAR]),
    .press   (ev_clear)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .Clock   (Clock),
    .Reset   (Reset),
    .key_raw (bus.KEY[KEY_LAP]),
    .press   (ev_lap)
  );

  sw_state_e     state_q;
  logic [PW-1:0] presc;
  logic          count_en_q;
  logic          count_clr_q;
  logic          running_q;
  logic          hold_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      presc       <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      running_q   <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      if (ev_clear) begin
        // clear outranks a simultaneous start and suppresses a coincident tick
        count_clr_q <= 1'b1;
        hold_q      <= 1'b0;
        presc       <= '0;
        state_q     <= (state_q == ST_RUN) ? ST_RUN : ST_IDLE;
        running_q   <= (state_q == ST_RUN);
      end else if (ev_start) begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            presc     <= '0;
          end
          ST_RUN: begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
            hold_q    <= 1'b0;
          end
          ST_PAUSE: begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            presc     <= '0;
            hold_q    <= 1'b0;
          end
        endcase
      end else if (state_q == ST_RUN) begin
        if (presc == PRESC_LAST) begin
          presc      <= '0;
          count_en_q <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
        if (ev_lap) begin
          hold_q <= ~hold_q;
        end
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.count_en  = count_en_q;
  assign bus.count_clr = count_clr_q;
  assign bus.running   = running_q;
  assign bus.hold      = hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: directed scenarios plus random key activity,
// every cycle compared against a behavioural model of the key/FSM rules.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (sw_if.master)
  );

  always #5 Clock = ~Clock;

  // model: key history window, accepted levels, pending presses, stopwatch state
  bit kin   [3][DB+1];
  bit m_db  [3];
  bit m_press [3];
  int m_state;
  int m_phase;
  bit m_hold;
  bit m_en;
  bit m_clr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] key);
    bit ev_st, ev_cl, ev_lp, all_diff;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i <= DB; i++) kin[k][i] = 1'b1;
        m_db[k]    = 1'b1;
        m_press[k] = 1'b0;
      end
      m_state = 0;
      m_phase = 0;
      m_hold  = 1'b0;
      m_en    = 1'b0;
      m_clr   = 1'b0;
    end else begin
      ev_st = m_press[0];
      ev_cl = m_press[1];
      ev_lp = m_press[2];
      // a key's level flips once the last DB synchronised samples all disagree with it
      for (int k = 0; k < 3; k++) begin
        all_diff = 1'b1;
        for (int i = 1; i <= DB; i++) if (kin[k][i] == m_db[k]) all_diff = 1'b0;
        m_press[k] = 1'b0;
        if (all_diff) begin
          m_press[k] = m_db[k];
          m_db[k]    = ~m_db[k];
        end
        for (int i = DB; i > 0; i--) kin[k][i] = kin[k][i-1];
        kin[k][0] = key[k];
      end
      m_en  = 1'b0;
      m_clr = 1'b0;
      if (ev_cl) begin
        m_clr   = 1'b1;
        m_hold  = 1'b0;
        m_phase = 0;
        if (m_state != 1) m_state = 0;
      end else if (ev_st) begin
        if (m_state == 0) begin
          m_state = 1;
          m_phase = 0;
        end else if (m_state == 1) begin
          m_state = 2;
          m_hold  = 1'b0;
        end else begin
          m_state = 1;
        end
      end else if (m_state == 1) begin
        m_phase = (m_phase + 1) % TD;
        m_en    = (m_phase == 0);
        if (ev_lp) m_hold = ~m_hold;
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge Clock);
    #1;
    model_step(Reset, sw_if.KEY);
    check_val("state",     32'(sw_if.state),     32'(m_state));
    check_val("running",   32'(sw_if.running),   32'(m_state == 1));
    check_val("hold",      32'(sw_if.hold),      32'(m_hold));
    check_val("count_en",  32'(sw_if.count_en),  32'(m_en));
    check_val("count_clr", 32'(sw_if.count_clr), 32'(m_clr));
  endtask

  task automatic hold_keys(input logic [3:0] k, input int n);
    sw_if.KEY = k;
    repeat (n) run_cycle();
  endtask

  int en_seen;
  int rem [4];
  logic [3:0] lv;

  initial begin
    sw_if.KEY = 4'hF;
    Reset = 1'b1;
    repeat (3) run_cycle();
    Reset = 1'b0;

    // start held 10 cycles: RUN after sync+debounce, ticks every TD cycles
    hold_keys(4'hE, 10);
    check_val("start_state", 32'(sw_if.state), 32'd1);
    en_seen = 0;
    sw_if.KEY = 4'hF;
    repeat (12) begin
      run_cycle();
      if (sw_if.count_en) en_seen++;
    end
    check_val("tick_count_12cyc", 32'(en_seen), 32'd3);

    // lap toggles hold in RUN; pausing drops it
    hold_keys(4'hB, 6);
    hold_keys(4'hF, 6);
    check_val("lap_hold", 32'(sw_if.hold), 32'd1);
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 6);
    check_val("pause_state", 32'(sw_if.state), 32'd2);
    check_val("pause_hold", 32'(sw_if.hold), 32'd0);

    // resume, pause again with a partial second, resume
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 5);
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 7);
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 6);
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 6);
    check_val("repause_state", 32'(sw_if.state), 32'd2);

    // start and clear together in PAUSE: clear wins, back to IDLE
    hold_keys(4'hC, 6);
    hold_keys(4'hF, 6);
    check_val("dual_press_state", 32'(sw_if.state), 32'd0);

    // bouncing start never settles long enough
    for (int i = 0; i < 3; i++) begin
      hold_keys(4'hE, 2);
      hold_keys(4'hF, 2);
    end
    hold_keys(4'hF, 8);
    check_val("bounce_state", 32'(sw_if.state), 32'd0);

    // reset during RUN with clear mid-debounce
    hold_keys(4'hE, 6);
    hold_keys(4'hF, 6);
    hold_keys(4'hD, 3);
    Reset = 1'b1;
    run_cycle();
    check_val("rst_state", 32'(sw_if.state), 32'd0);
    check_val("rst_clr", 32'(sw_if.count_clr), 32'd0);
    check_val("rst_running", 32'(sw_if.running), 32'd0);
    Reset = 1'b0;
    hold_keys(4'hD, 8);
    hold_keys(4'hF, 6);

    // random key activity with occasional reset
    for (int k = 0; k < 4; k++) begin
      rem[k] = 0;
      lv[k]  = 1'b1;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          lv[k]  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
          rem[k] = $urandom_range(1, 12);
        end
        rem[k]--;
      end
      sw_if.KEY = lv;
      Reset = ($urandom_range(0, 499) == 0);
      run_cycle();
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, Clock cycles per count_en pulse (1 s at 50 MHz); legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronised cycles before a key change is accepted (20 ms); legal range >= 1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Clock  input  1  system clock, all flops on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 KEY  input  4  raw push-buttons, active-low, asynchronous to Clock.
REQ-007 count_en  output  1  one-cycle pulse; BCD counter increments by one.
REQ-008 count_clr  output  1  one-cycle pulse; BCD counter returns to 000.
REQ-009 running  output  1  high while state is RUN.
REQ-010 hold  output  1  high while the downstream display is frozen (lap).
REQ-011 state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2; 3 never driven.

Function
REQ-012 Each KEY bit SHALL pass a 2-flop synchroniser before any other use.
REQ-013 Per key, a debounced level SHALL change only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL restart that key's counter.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases generate nothing.
REQ-015 Key roles: KEY[0] start/stop, KEY[1] clear, KEY[2] lap/hold toggle; KEY[3] SHALL be ignored.
REQ-016 FSM in IDLE: start -> RUN; clear -> count_clr pulse, stay IDLE.
REQ-017 FSM in RUN: start -> PAUSE; clear -> count_clr pulse, prescaler to 0, stay RUN.
REQ-018 FSM in PAUSE: start -> RUN; clear -> count_clr pulse, go to IDLE.
REQ-019 Same-cycle start and clear: clear SHALL take priority and start SHALL be discarded.
REQ-020 State, count_clr and hold SHALL update on the rising edge after the press-event pulse (1-cycle latency from event).
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrapping to 0; it SHALL hold its value in PAUSE and be 0 in IDLE.
REQ-022 count_en SHALL pulse for exactly one cycle in the cycle the prescaler wraps from TICK_DIV-1 to 0 while in RUN; never in IDLE or PAUSE.
REQ-023 Entering RUN from IDLE SHALL start the prescaler at 0, so the first count_en occurs TICK_DIV cycles after entry.
REQ-024 Resuming from PAUSE SHALL continue the held prescaler value (partial second preserved).
REQ-025 count_en and count_clr SHALL never be high in the same cycle; clear wins.
REQ-026 hold SHALL toggle on a lap event only in RUN; leaving RUN for PAUSE or IDLE, or any clear, SHALL force hold to 0.
REQ-027 Prescaler width SHALL be ceil(log2(TICK_DIV)) bits; debounce counter width ceil(log2(DEBOUNCE_CYCLES+1)) bits; no overflow permitted.

Reset
REQ-028 While Reset is high: state=IDLE, prescaler=0, debounce counters=0, synchroniser and debounced levels=1 (released), count_en=0, count_clr=0, running=0, hold=0.
REQ-029 Reset mid-operation SHALL abort any pending debounce and SHALL NOT emit count_clr; downstream clear is a separate responsibility.
REQ-030 After Reset deasserts, a key held low SHALL register a press only after synchroniser + DEBOUNCE_CYCLES cycles.

Structure
REQ-031 Shared package SHALL hold the state encoding (IDLE/RUN/PAUSE) and key-index constants (KEY_START=0, KEY_CLEAR=1, KEY_LAP=2).
REQ-032 One sub-module, key_debounce (synchroniser + debounce + press pulse, one key, parameter DEBOUNCE_CYCLES), SHALL be instantiated three times.
REQ-033 All outputs SHALL be registered.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-034 Hold KEY[0] low 10 cycles from IDLE -> state=1, running=1; count_en every 4th cycle thereafter, first 4 cycles after entry.
REQ-035 KEY[0] bounces 0/1 every 2 cycles for 12 cycles, then released -> no press event, state stays 0.
REQ-036 RUN, pause after prescaler=2, resume -> first count_en after resume arrives 2 cycles after re-entering RUN.
REQ-037 KEY[0] and KEY[1] debounced on same cycle in PAUSE -> one count_clr pulse, state=0, no count_en.
REQ-038 RUN, KEY[2] press -> hold=1; KEY[0] press -> state=2, hold=0.
REQ-039 Reset asserted mid-RUN for 1 cycle, with KEY[1] mid-debounce -> all outputs 0, state=0, no count_clr after release until new full debounce.
